uart_axi_mc: RTL and testbench

Multi-channel UART with an AXI4-Lite slave: `NUM_CH` independent 8-bit channels behind one register port.

- Each channel has:
  - a `FIFO_DEPTH`-entry TX FIFO and RX FIFO,
  - a serializer and a deserializer,
  - per-frame configurable baud divisor and parity,
  - sticky error flags and its own interrupt line.
- It replaces single-channel UART peripherals where several serial links share one bus slot.

---
 rtl/uart_axi_mc.sv | 279 +++++++++++++++++++++++++++
 tb/tb_uart_axi_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axi_mc.sv
// Multi-channel UART behind an AXI4-Lite slave. Each channel has TX/RX FIFOs,
// a serializer/deserializer with per-frame baud divisor/parity, and sticky errors.

module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push, w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rp];

    always_ff @(posedge i_clk) if (w_push) r_mem[r_wp] <= i_din;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0; r_rp <= '0; r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

module uart_ch #(
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd27
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr,
    input  logic [1:0]  i_woff,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    input  logic        i_rd,
    input  logic [1:0]  i_roff,
    output logic [31:0] o_rdata,
    input  logic        i_rxd,
    output logic        o_txd,
    output logic        o_intr
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
    state_t      r_tst, w_tst_nx, r_rst, w_rst_nx;
    logic [19:0] r_ctrl;
    logic [3:0]  r_err;   // {TXOVF, PERR, FERR, RXOVR}
    logic [3:0]  w_clr;
    logic [15:0] w_div;
    logic        w_data_we, w_tx_full, w_tx_empty, w_tx_pop, w_rx_full, w_rx_empty;
    logic [7:0]  w_tx_dout, w_rx_dout;
    logic [15:0] r_tcnt, r_tdiv, r_rcnt, r_rdiv;
    logic [2:0]  r_tbit, r_rbit;
    logic [7:0]  r_tsh, r_rsh;
    logic        r_tpen, r_tpar, r_txd, r_s1, r_s2, r_s3, r_rpen, r_rpodd, r_rperr;
    logic        w_ttick, w_rtick, w_fall, w_rx_push, w_ferr, w_perr, w_ovr;
    logic        w_unused_ok;

    assign w_div      = (r_ctrl[15:0] < 16'd4) ? 16'd4 : r_ctrl[15:0];
    assign w_data_we  = i_wr & (i_woff == 2'd0) & i_wstrb[0];
    assign w_clr      = (i_wr && i_woff == 2'd1 && i_wstrb[0]) ? i_wdata[7:4] : 4'b0;
    assign w_ttick    = (r_tcnt == '0);
    assign w_rtick    = (r_rcnt == '0);
    assign w_fall     = r_s3 & ~r_s2;
    assign o_txd      = r_txd;
    assign o_intr     = (r_ctrl[19] & ~w_rx_empty) | (r_ctrl[18] & w_tx_empty) | (|r_err);
    assign w_unused_ok = ^{i_wdata[31:20], i_wstrb[3]};

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_txf (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_data_we), .i_pop(w_tx_pop),
        .i_din(i_wdata[7:0]), .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty));
    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rxf (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_rx_push), .i_pop(i_rd && i_roff == 2'd0),
        .i_din(r_rsh), .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty));

    always_comb begin
        o_rdata = '0;
        case (i_roff)
            2'd0:    if (!w_rx_empty) o_rdata[7:0] = w_rx_dout;
            2'd1:    o_rdata[7:0] = {r_err, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
            2'd2:    o_rdata[19:0] = r_ctrl;
            default: o_rdata = '0;
        endcase
    end

    always_comb begin
        w_tst_nx = r_tst;
        w_tx_pop = 1'b0;
        case (r_tst)
            S_IDLE:  if (!w_tx_empty) begin w_tst_nx = S_START; w_tx_pop = 1'b1; end
            S_START: if (w_ttick) w_tst_nx = S_DATA;
            S_DATA:  if (w_ttick && r_tbit == 3'd7) w_tst_nx = r_tpen ? S_PAR : S_STOP;
            S_PAR:   if (w_ttick) w_tst_nx = S_STOP;
            S_STOP:  if (w_ttick) begin
                         w_tst_nx = w_tx_empty ? S_IDLE : S_START;
                         w_tx_pop = ~w_tx_empty;
                     end
            default: w_tst_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_rst_nx  = r_rst;
        w_rx_push = 1'b0; w_ferr = 1'b0; w_perr = 1'b0; w_ovr = 1'b0;
        case (r_rst)
            S_IDLE:  if (w_fall) w_rst_nx = S_START;
            S_START: if (w_rtick) w_rst_nx = r_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rtick && r_rbit == 3'd7) w_rst_nx = r_rpen ? S_PAR : S_STOP;
            S_PAR:   if (w_rtick) w_rst_nx = S_STOP;
            S_STOP:  if (w_rtick) begin
                         w_rst_nx = S_IDLE;
                         if (!r_s2)          w_ferr    = 1'b1;
                         else if (r_rperr)   w_perr    = 1'b1;
                         else if (w_rx_full) w_ovr     = 1'b1;
                         else                w_rx_push = 1'b1;
                     end
            default: w_rst_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl <= {4'b0, DEFAULT_BAUD_DIV};
            r_err  <= '0;
        end else begin
            if (i_wr && i_woff == 2'd2) begin
                if (i_wstrb[0]) r_ctrl[7:0]   <= i_wdata[7:0];
                if (i_wstrb[1]) r_ctrl[15:8]  <= i_wdata[15:8];
                if (i_wstrb[2]) r_ctrl[19:16] <= i_wdata[19:16];
            end
            // set beats a same-cycle write-1-to-clear
            r_err <= (r_err & ~w_clr) | {w_data_we & w_tx_full, w_perr, w_ferr, w_ovr};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tst <= S_IDLE; r_tcnt <= '0; r_tdiv <= 16'd4; r_tbit <= '0; r_tsh <= '0;
            r_tpen <= 1'b0; r_tpar <= 1'b0; r_txd <= 1'b1;
        end else begin
            r_tst <= w_tst_nx;
            if (w_tx_pop) begin
                r_tsh  <= w_tx_dout; r_tdiv <= w_div; r_tcnt <= w_div - 16'd1; r_tbit <= '0;
                r_tpen <= r_ctrl[16]; r_tpar <= (^w_tx_dout) ^ r_ctrl[17];
            end else if (r_tst != S_IDLE) begin
                if (w_ttick) begin
                    r_tcnt <= r_tdiv - 16'd1;
                    if (r_tst == S_DATA) r_tbit <= r_tbit + 3'd1;
                end else r_tcnt <= r_tcnt - 16'd1;
            end
            case (r_tst)
                S_START: r_txd <= 1'b0;
                S_DATA:  r_txd <= r_tsh[r_tbit];
                S_PAR:   r_txd <= r_tpar;
                default: r_txd <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst <= S_IDLE; r_s1 <= 1'b1; r_s2 <= 1'b1; r_s3 <= 1'b1;
            r_rcnt <= '0; r_rdiv <= 16'd4; r_rbit <= '0; r_rsh <= '0;
            r_rpen <= 1'b0; r_rpodd <= 1'b0; r_rperr <= 1'b0;
        end else begin
            r_rst <= w_rst_nx;
            r_s1 <= i_rxd; r_s2 <= r_s1; r_s3 <= r_s2;
            if (r_rst == S_IDLE) begin
                if (w_fall) begin
                    r_rdiv <= w_div; r_rcnt <= (w_div >> 1) - 16'd1; r_rbit <= '0;
                    r_rpen <= r_ctrl[16]; r_rpodd <= r_ctrl[17]; r_rperr <= 1'b0;
                end
            end else if (w_rtick) begin
                r_rcnt <= r_rdiv - 16'd1;
                if (r_rst == S_DATA) begin r_rsh[r_rbit] <= r_s2; r_rbit <= r_rbit + 3'd1; end
                if (r_rst == S_PAR)  r_rperr <= (^r_rsh) ^ r_rpodd ^ r_s2;
            end else r_rcnt <= r_rcnt - 16'd1;
        end
    end
endmodule

module uart_axi_mc #(
    parameter int          NUM_CH           = 4,
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd27
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic [31:0]       s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [31:0]       s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [NUM_CH-1:0] uart_rxd,
    output logic [NUM_CH-1:0] uart_txd,
    output logic [NUM_CH-1:0] intr
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    logic                   w_wr_hs, w_rd_hs, w_wok, w_rok, w_unused_ok;
    logic [CW-1:0]          w_wch, w_rch;
    logic [NUM_CH-1:0]      w_wr_en, w_rd_en;
    logic [NUM_CH-1:0][31:0] w_rdata;
    logic [31:0]            w_rsel, r_rdata;
    logic                   r_bvalid, r_rvalid;
    logic [1:0]             r_bresp, r_rresp;

    assign w_wr_hs = s_axi_awvalid & s_axi_wvalid & ~r_bvalid;
    assign w_rd_hs = s_axi_arvalid & ~r_rvalid;
    assign w_wch   = s_axi_awaddr[4+CW-1:4];
    assign w_rch   = s_axi_araddr[4+CW-1:4];
    assign w_wok   = (32'(w_wch) < 32'(NUM_CH));
    assign w_rok   = (32'(w_rch) < 32'(NUM_CH));
    assign s_axi_awready = w_wr_hs;
    assign s_axi_wready  = w_wr_hs;
    assign s_axi_arready = w_rd_hs;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign w_unused_ok   = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:4+CW], s_axi_awaddr[1:0],
                             s_axi_araddr[31:4+CW], s_axi_araddr[1:0]};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr_en[g] = w_wr_hs & (w_wch == CW'(g));
        assign w_rd_en[g] = w_rd_hs & (w_rch == CW'(g));
        uart_ch #(.FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_BAUD_DIV(DEFAULT_BAUD_DIV)) u_ch (
            .i_clk(s_axi_aclk), .i_rst_n(s_axi_aresetn),
            .i_wr(w_wr_en[g]), .i_woff(s_axi_awaddr[3:2]), .i_wdata(s_axi_wdata), .i_wstrb(s_axi_wstrb),
            .i_rd(w_rd_en[g]), .i_roff(s_axi_araddr[3:2]), .o_rdata(w_rdata[g]),
            .i_rxd(uart_rxd[g]), .o_txd(uart_txd[g]), .o_intr(intr[g]));
    end

    always_comb begin
        w_rsel = '0;
        for (int c = 0; c < NUM_CH; c++) if (w_rch == CW'(c)) w_rsel = w_rdata[c];
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_bvalid <= 1'b0; r_bresp <= 2'b00; r_rvalid <= 1'b0; r_rresp <= 2'b00; r_rdata <= '0;
        end else begin
            if (w_wr_hs) begin
                r_bvalid <= 1'b1; r_bresp <= w_wok ? 2'b00 : 2'b10;
            end else if (s_axi_bready) r_bvalid <= 1'b0;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1; r_rresp <= w_rok ? 2'b00 : 2'b10; r_rdata <= w_rok ? w_rsel : '0;
            end else if (s_axi_rready) r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_axi_mc.sv
// Directed bench for uart_axi_mc: loopback, parity, FIFO limits, decode, framing, reset.
module tb_uart_axi_mc;
    localparam int NCH = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NCH-1:0] uart_rxd, uart_txd, intr;
    logic        loop0 = 1'b0, rx_drv = 1'b1;

    assign uart_rxd = {{(NCH-1){1'b1}}, loop0 ? uart_txd[0] : rx_drv};

    uart_axi_mc #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .DEFAULT_BAUD_DIV(16'd27)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rstn),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd), .intr(intr));

    int checks = 0, failures = 0;
    logic [31:0] q_data[$], q_mask[$];
    logic [1:0]  q_resp[$];
    logic        q_bit[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input string tag);
        int n;
        q_resp.push_back(er);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) check({tag, " aw_timeout"}, 32'd1, 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, " bvalid"}, 32'(bvalid), 32'd1);
        check({tag, " bresp"}, 32'(bresp), 32'(q_resp.pop_front()));
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] m,
                          input logic [1:0] er, input string tag);
        int n;
        logic [31:0] ed, em;
        q_data.push_back(exp); q_mask.push_back(m); q_resp.push_back(er);
        araddr = a; arvalid = 1'b1; #1;
        n = 0;
        while (!arready && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) check({tag, " ar_timeout"}, 32'd1, 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) check({tag, " r_timeout"}, 32'd1, 32'd0);
        ed = q_data.pop_front(); em = q_mask.pop_front();
        check({tag, " rdata"}, rdata & em, ed);
        check({tag, " rresp"}, 32'(rresp), 32'(q_resp.pop_front()));
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // Called right after a DATA write on an idle channel 0 at div=8.
    task automatic tx_frame(input logic [7:0] d, input bit pen, input bit pbit, input string tag);
        int i;
        q_bit.push_back(1'b0);
        for (int k = 0; k < 8; k++) q_bit.push_back(d[k]);
        if (pen) q_bit.push_back(pbit);
        q_bit.push_back(1'b1);
        check({tag, " idle_before_start"}, 32'(uart_txd[0]), 32'd1);
        @(posedge clk); #1;
        check({tag, " start_latency"}, 32'(uart_txd[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        i = 0;
        while (q_bit.size() > 0) begin
            check($sformatf("%s bit%0d", tag, i), 32'(uart_txd[0]), 32'(q_bit.pop_front()));
            repeat (8) @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input bit pen, input bit pbit, input bit stop);
        rx_drv = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            rx_drv = d[k];
            repeat (8) @(posedge clk);
            #1;
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (8) @(posedge clk);
            #1;
        end
        rx_drv = stop;
        repeat (8) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst txd", 32'(uart_txd), 32'h7);
        check("rst intr", 32'(intr), 32'h0);
        check("rst axi", {25'b0, awready, wready, bvalid, arready, rvalid, bresp == 2'b00, rresp == 2'b00},
              32'h3);
        check("rst rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        axi_rd(32'h08, 32'h1B, 32'hFFFF_FFFF, 2'b00, "ctrl_default");
        axi_rd(32'h04, 32'h0A, 32'hFFFF_FFFF, 2'b00, "status_default");

        // Loopback, div=8, no parity
        axi_wr(32'h08, 32'h8, 4'hF, 2'b00, "ctrl0_div8");
        loop0 = 1'b1;
        axi_wr(32'h00, 32'hA5, 4'hF, 2'b00, "data0_a5");
        tx_frame(8'hA5, 1'b0, 1'b0, "tx_a5");
        repeat (5) @(posedge clk);
        #1;
        axi_rd(32'h04, 32'h00, 32'h08, 2'b00, "lb rx_not_empty");
        axi_rd(32'h00, 32'hA5, 32'hFFFF_FFFF, 2'b00, "lb data");
        axi_rd(32'h04, 32'h0A, 32'hFFFF_FFFF, 2'b00, "lb status_after");

        // Odd parity loopback, then injected bad parity
        axi_wr(32'h08, 32'h30008, 4'hF, 2'b00, "ctrl0_odd");
        axi_wr(32'h00, 32'h03, 4'hF, 2'b00, "data0_03");
        tx_frame(8'h03, 1'b1, 1'b1, "tx_03par");
        repeat (5) @(posedge clk);
        #1;
        axi_rd(32'h00, 32'h03, 32'hFFFF_FFFF, 2'b00, "par rx_data");
        loop0 = 1'b0;
        send_rx(8'h03, 1'b1, 1'b0, 1'b1);
        axi_rd(32'h04, 32'h48, 32'hF8, 2'b00, "par perr_set");
        check("par intr_set", 32'(intr[0]), 32'd1);
        axi_wr(32'h04, 32'h40, 4'h1, 2'b00, "par w1c");
        check("par intr_clr", 32'(intr[0]), 32'd0);
        axi_rd(32'h04, 32'h0A, 32'hFFFF_FFFF, 2'b00, "par status_clr");

        // Framing error and false start
        axi_wr(32'h08, 32'h8, 4'hF, 2'b00, "ctrl0_noparity");
        send_rx(8'h55, 1'b0, 1'b0, 1'b0);
        axi_rd(32'h04, 32'h28, 32'hF8, 2'b00, "ferr set");
        axi_wr(32'h04, 32'h20, 4'h1, 2'b00, "ferr w1c");
        rx_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        axi_rd(32'h04, 32'h0A, 32'hFFFF_FFFF, 2'b00, "false_start");

        // FIFO boundaries on channel 1 with a stalled serializer
        axi_wr(32'h18, 32'hFFFF, 4'hF, 2'b00, "ctrl1_slow");
        for (int k = 0; k < DEPTH + 2; k++) axi_wr(32'h10, 32'(k + 1), 4'h1, 2'b00, "data1_fill");
        axi_rd(32'h14, 32'h89, 32'hFF, 2'b00, "fifo full_txovf");
        check("fifo intr1", 32'(intr[1]), 32'd1);
        axi_rd(32'h10, 32'h0, 32'hFFFF_FFFF, 2'b00, "fifo rx_empty_read");

        // Decode, aliasing and byte strobes
        axi_wr(32'h38, 32'h1234, 4'hF, 2'b10, "dec ch3_wr");
        axi_rd(32'h38, 32'h0, 32'hFFFF_FFFF, 2'b10, "dec ch3_rd_ctrl");
        axi_rd(32'h30, 32'h0, 32'hFFFF_FFFF, 2'b10, "dec ch3_rd_data");
        axi_wr(32'h28, 32'h10, 4'hF, 2'b00, "dec ch2_ctrl");
        axi_rd(32'h18, 32'hFFFF, 32'hFFFF_FFFF, 2'b00, "dec ch1_ctrl_kept");
        axi_rd(32'h28, 32'h10, 32'hFFFF_FFFF, 2'b00, "dec ch2_ctrl");
        axi_rd(32'hF000_0018, 32'hFFFF, 32'hFFFF_FFFF, 2'b00, "dec alias_high");
        axi_wr(32'h28, 32'hFFFF_FFFF, 4'h1, 2'b00, "strb ctrl_b0");
        axi_rd(32'h28, 32'hFF, 32'hFFFF_FFFF, 2'b00, "strb ctrl_b0");
        axi_wr(32'h20, 32'h55, 4'h2, 2'b00, "strb data_nob0");
        axi_rd(32'h24, 32'h0A, 32'hFFFF_FFFF, 2'b00, "strb data_ignored");
        axi_rd(32'h0C, 32'h0, 32'hFFFF_FFFF, 2'b00, "reserved_rd");

        // Reset during data bit 3 of 0xA5 (bit value 0)
        axi_wr(32'h00, 32'hA5, 4'hF, 2'b00, "data0_rst");
        repeat (35) @(posedge clk);
        #1;
        check("rst_mid pre_txd0", 32'(uart_txd[0]), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid txd", 32'(uart_txd), 32'h7);
        check("rst_mid intr", 32'(intr), 32'h0);
        check("rst_mid axi", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        axi_rd(32'h08, 32'h1B, 32'hFFFF_FFFF, 2'b00, "rst_mid ctrl0");
        axi_rd(32'h18, 32'h1B, 32'hFFFF_FFFF, 2'b00, "rst_mid ctrl1");
        axi_rd(32'h14, 32'h0A, 32'hFFFF_FFFF, 2'b00, "rst_mid status1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
